divisor_scheduler: RTL and testbench

DIVISOR_SCHEDULER -- requirements
Module: divisor_scheduler

---
 rtl/divisor_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_divisor_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_scheduler.sv
// rtl/divisor_scheduler.sv - round-robin issue and in-order retire for a fixed-latency signed divider stage chain
//
// Two requesters share one unsigned divider stage chain of fixed depth `BIT_SIZE.
// Operands are issued as magnitudes with their signs. Results leave the chain
// after exactly `BIT_SIZE cycles. They are then sign-corrected and registered
// as a one-cycle response.
//
// Ports:
//   CLK, RSTa             clock (rising edge); asynchronous active-low reset
//   en                    enable issuing; low drains in-flight work, then idles
//   req0/req1             requester r has an operation pending
//   num0/den0, num1/den1  two's-complement operands per requester
//   ack0/ack1             operands of requester r taken this cycle (combinational)
//   p_start, p_q, p_m,    issue port into the stage chain
//   p_accu, p_sign_num, p_sign_den
//   p_done, p_q_out,      tail of the stage chain
//   p_accu_out, p_sign_num_out, p_sign_den_out
//   rsp_valid, rsp_id     registered one-cycle result strobe and requester index
//   quotient, remainder   sign-corrected results
//   dz_o                  divide-by-zero flag with rsp_valid (only with DIV_ZERO_DETECT_EN)
//   busy                  not idle, or work still in flight
//
// Build option: define DIV_ZERO_DETECT_EN to enable divide-by-zero tagging.

`ifndef BIT_SIZE
`define BIT_SIZE 8
`endif
`ifndef LAST_BIT
`define LAST_BIT 7
`endif

module divisor_scheduler (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               en,
    input  logic               req0,
    input  logic               req1,
    input  logic [`LAST_BIT:0] num0,
    input  logic [`LAST_BIT:0] den0,
    input  logic [`LAST_BIT:0] num1,
    input  logic [`LAST_BIT:0] den1,
    output logic               ack0,
    output logic               ack1,
    output logic               p_start,
    output logic [`LAST_BIT:0] p_q,
    output logic [`LAST_BIT:0] p_m,
    output logic [`LAST_BIT:0] p_accu,
    output logic               p_sign_num,
    output logic               p_sign_den,
    input  logic               p_done,
    input  logic [`LAST_BIT:0] p_q_out,
    input  logic [`LAST_BIT:0] p_accu_out,
    input  logic               p_sign_num_out,
    input  logic               p_sign_den_out,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [`LAST_BIT:0] quotient,
    output logic [`LAST_BIT:0] remainder,
`ifdef DIV_ZERO_DETECT_EN
    output logic               dz_o,
`endif
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_last_id;
    logic [`LAST_BIT:0] r_inflight;
    logic [`LAST_BIT:0] r_tag_valid;
    logic [`LAST_BIT:0] r_tag_id;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [`LAST_BIT:0] r_quot;
    logic [`LAST_BIT:0] r_rem;

    logic               w_grant_ok;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_issue;
    logic [`LAST_BIT:0] w_num;
    logic [`LAST_BIT:0] w_den;
    logic               w_done;
    logic [`LAST_BIT:0] w_q_fix;
    logic [`LAST_BIT:0] w_r_fix;
    logic [`LAST_BIT:0] w_quot;
    logic [`LAST_BIT:0] w_rem;

    // Magnitude fits N unsigned bits, so the most negative value keeps its weight.
    function automatic logic [`LAST_BIT:0] f_abs(input logic [`LAST_BIT:0] x);
        return x[`LAST_BIT] ? (~x + `BIT_SIZE'(1)) : x;
    endfunction

    // Acks are also gated by en, so dropping en blocks an issue in the same cycle.
    // r_last_id starts at 1, so req0 wins the first tie after reset.
    assign w_grant_ok = (r_state == S_RUN) && en;
    assign w_gnt1     = w_grant_ok && req1 && (!req0 || !r_last_id);
    assign w_gnt0     = w_grant_ok && req0 && !w_gnt1;
    assign w_issue    = w_gnt0 || w_gnt1;
    assign ack0       = w_gnt0;
    assign ack1       = w_gnt1;

    assign w_num      = w_gnt1 ? num1 : num0;
    assign w_den      = w_gnt1 ? den1 : den0;

    assign p_start    = w_issue;
    assign p_q        = w_issue ? f_abs(w_num) : '0;
    assign p_m        = w_issue ? f_abs(w_den) : '0;
    assign p_accu     = '0;
    assign p_sign_num = w_issue && w_num[`LAST_BIT];
    assign p_sign_den = w_issue && w_den[`LAST_BIT];

    // Only a p_done aligned with a live tag retires work.
    // A stale p_done left over from a discarded operation therefore does nothing.
    assign w_done  = p_done && r_tag_valid[`LAST_BIT];

    assign w_q_fix = (p_sign_num_out ^ p_sign_den_out) ? (~p_q_out + `BIT_SIZE'(1)) : p_q_out;
    assign w_r_fix = p_sign_num_out ? (~p_accu_out + `BIT_SIZE'(1)) : p_accu_out;

`ifdef DIV_ZERO_DETECT_EN
    logic               r_tag_dz [0:`LAST_BIT];
    logic [`LAST_BIT:0] r_tag_num [0:`LAST_BIT];
    logic               r_dz;

    // Operand history travels with the tag. It has no reset because the valid bits qualify it.
    always_ff @(posedge CLK) begin
        r_tag_dz[0]  <= (w_den == '0);
        r_tag_num[0] <= w_num;
        for (int i = 1; i < `BIT_SIZE; i++) begin
            r_tag_dz[i]  <= r_tag_dz[i-1];
            r_tag_num[i] <= r_tag_num[i-1];
        end
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa)       r_dz <= 1'b0;
        else if (w_done) r_dz <= r_tag_dz[`LAST_BIT];
    end

    assign w_quot = r_tag_dz[`LAST_BIT] ? '1 : w_q_fix;
    assign w_rem  = r_tag_dz[`LAST_BIT] ? r_tag_num[`LAST_BIT] : w_r_fix;
    assign dz_o   = r_dz;
`else
    assign w_quot = w_q_fix;
    assign w_rem  = w_r_fix;
`endif

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (en) w_state_next = S_RUN;
            S_RUN:   if (!en) w_state_next = S_DRAIN;
            S_DRAIN: begin
                if (en)                                   w_state_next = S_RUN;
                else if ((r_inflight == '0) && !w_done)  w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            r_last_id   <= 1'b1;
            r_inflight  <= '0;
            r_tag_valid <= '0;
            r_tag_id    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
        end else begin
            if (w_issue) r_last_id <= w_gnt1;
            case ({w_issue, w_done})
                2'b10:   r_inflight <= r_inflight + `BIT_SIZE'(1);
                2'b01:   r_inflight <= r_inflight - `BIT_SIZE'(1);
                default: r_inflight <= r_inflight;
            endcase
            r_tag_valid <= {r_tag_valid[`LAST_BIT-1:0], w_issue};
            r_tag_id    <= {r_tag_id[`LAST_BIT-1:0], w_gnt1};
            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_id <= r_tag_id[`LAST_BIT];
                r_quot   <= w_quot;
                r_rem    <= w_rem;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign busy      = (r_state != S_IDLE) || (r_inflight != '0);

endmodule

// File: tb/tb_divisor_scheduler.sv
// tb/tb_divisor_scheduler.sv - scoreboard bench for divisor_scheduler with a behavioural stage chain

`ifndef BIT_SIZE
`define BIT_SIZE 8
`endif
`ifndef LAST_BIT
`define LAST_BIT 7
`endif

module tb_divisor_scheduler;
    localparam int N = 8;

    logic       CLK = 1'b0;
    logic       RSTa = 1'b0;
    logic       en = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] num0 = '0, den0 = '0, num1 = '0, den1 = '0;
    logic       ack0, ack1, p_start, p_sign_num, p_sign_den;
    logic [7:0] p_q, p_m, p_accu;
    logic       p_done, p_sign_num_out, p_sign_den_out;
    logic [7:0] p_q_out, p_accu_out;
    logic       rsp_valid, rsp_id, busy;
    logic [7:0] quotient, remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic       dz_o;
`endif

    divisor_scheduler dut (
        .CLK(CLK), .RSTa(RSTa), .en(en), .req0(req0), .req1(req1),
        .num0(num0), .den0(den0), .num1(num1), .den1(den1),
        .ack0(ack0), .ack1(ack1),
        .p_start(p_start), .p_q(p_q), .p_m(p_m), .p_accu(p_accu),
        .p_sign_num(p_sign_num), .p_sign_den(p_sign_den),
        .p_done(p_done), .p_q_out(p_q_out), .p_accu_out(p_accu_out),
        .p_sign_num_out(p_sign_num_out), .p_sign_den_out(p_sign_den_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .quotient(quotient), .remainder(remainder),
`ifdef DIV_ZERO_DETECT_EN
        .dz_o(dz_o),
`endif
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural stage chain: N cycles of latency, no stall, and no reset.
    // Work discarded by a reset still comes out of its tail.
    logic [N-1:0] ch_v = '0;
    logic [7:0]   ch_q [N];
    logic [7:0]   ch_r [N];
    logic         ch_sn [N];
    logic         ch_sd [N];

    always @(posedge CLK) begin
        ch_v     <= {ch_v[N-2:0], p_start};
        ch_q[0]  <= (p_m == 8'd0) ? 8'hFF : (p_q / p_m);
        ch_r[0]  <= (p_m == 8'd0) ? p_q : (p_q % p_m);
        ch_sn[0] <= p_sign_num;
        ch_sd[0] <= p_sign_den;
        for (int i = 1; i < N; i++) begin
            ch_q[i]  <= ch_q[i-1];
            ch_r[i]  <= ch_r[i-1];
            ch_sn[i] <= ch_sn[i-1];
            ch_sd[i] <= ch_sd[i-1];
        end
    end

    assign p_done         = ch_v[N-1];
    assign p_q_out        = ch_q[N-1];
    assign p_accu_out     = ch_r[N-1];
    assign p_sign_num_out = ch_sn[N-1];
    assign p_sign_den_out = ch_sd[N-1];

    typedef struct {
        logic       id;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic [7:0] e0_q, e0_r, e1_q, e1_r;
    logic       e0_dz, e1_dz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic id, input logic [7:0] n, input logic [7:0] d,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz);
        if (id) begin
            num1 = n; den1 = d; e1_q = eq; e1_r = er; e1_dz = edz;
        end else begin
            num0 = n; den0 = d; e0_q = eq; e0_r = er; e0_dz = edz;
        end
    endtask

    // Called at a falling edge: records the expected result for each ack seen this cycle.
    task automatic push_acks();
        if (ack0) sb.push_back('{1'b0, e0_q, e0_r, e0_dz, cyc + N + 1});
        if (ack1) sb.push_back('{1'b1, e1_q, e1_r, e1_dz, cyc + N + 1});
    endtask

    // Called just after a rising edge. Returns just after the edge that captured the grant.
    task automatic issue1(input logic id, input bit do_push);
        bit got;
        got = 0;
        if (id) req1 = 1'b1; else req0 = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLK);
            if (id ? ack1 : ack0) begin
                got = 1;
                if (do_push) push_acks();
            end
            @(posedge CLK); #1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("issue_ack_seen", got, 1'b1);
    endtask

    task automatic wait_drained();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge CLK);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RSTa && rsp_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rsp_id %0d q 0x%0h with nothing pending, expected no response",
                         rsp_id, quotient);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("rsp_latency_cycle", cyc, e.due);
`ifdef DIV_ZERO_DETECT_EN
                chk("dz_o", dz_o, e.dz);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_ack, early_idle;
        int nack;

        // Reset state, with requests and en already active.
        en = 1'b1; req0 = 1'b1; req1 = 1'b1;
        num0 = 8'd9; den0 = 8'd2;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ack0", ack0, 1'b0);
        chk("reset_ack1", ack1, 1'b0);
        chk("reset_p_start", p_start, 1'b0);
        chk("reset_quotient", quotient, 8'd0);
        chk("reset_remainder", remainder, 8'd0);
`ifdef DIV_ZERO_DETECT_EN
        chk("reset_dz_o", dz_o, 1'b0);
`endif
        req0 = 1'b0; req1 = 1'b0;
        @(posedge CLK); #1;
        RSTa = 1'b1;
        @(posedge CLK); #1;

        // Both requesting for four cycles: grants alternate starting with req0.
        set_op(1'b0, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0);
        set_op(1'b1, 8'hF7, 8'd4, 8'hFE, 8'hFF, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("rr_ack0", ack0, (i % 2) == 0);
            chk("rr_ack1", ack1, (i % 2) == 1);
            push_acks();
            @(posedge CLK); #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_drained();
        @(posedge CLK); #1;

        // Directed single operations, including sign and boundary cases.
        set_op(1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);     issue1(1'b0, 1);
        set_op(1'b0, 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);     issue1(1'b0, 1);
        set_op(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);    issue1(1'b1, 1);
        set_op(1'b0, 8'd127, 8'h80, 8'h00, 8'h7F, 1'b0);   issue1(1'b0, 1);
        set_op(1'b1, 8'h80, 8'd7, 8'hEE, 8'hFE, 1'b0);     issue1(1'b1, 1);
        set_op(1'b0, 8'd7, 8'd100, 8'h00, 8'h07, 1'b0);    issue1(1'b0, 1);
        set_op(1'b1, 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1);     issue1(1'b1, 1);
`ifdef DIV_ZERO_DETECT_EN
        set_op(1'b0, 8'hC9, 8'd0, 8'hFF, 8'hC9, 1'b1);     issue1(1'b0, 1);
`else
        set_op(1'b0, 8'hC9, 8'd0, 8'h01, 8'hC9, 1'b0);     issue1(1'b0, 1);
`endif
        wait_drained();
        @(posedge CLK); #1;

        // Three operations, then en low: no more acks, busy until the last response.
        set_op(1'b0, 8'd20, 8'd3, 8'd6, 8'd2, 1'b0);
        set_op(1'b1, 8'd21, 8'hFD, 8'hF9, 8'd0, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        nack = 0;
        for (int k = 0; k < 10 && nack < 3; k++) begin
            @(negedge CLK);
            if (ack0 || ack1) nack++;
            push_acks();
            @(posedge CLK); #1;
        end
        chk("drain_three_issued", nack, 3);
        en = 1'b0;
        saw_ack = 0; early_idle = 0;
        for (int k = 0; k < 30 && sb.size() != 0; k++) begin
            @(negedge CLK); #1;
            if (ack0 || ack1) saw_ack = 1;
            if (!busy) early_idle = 1;
        end
        chk("drain_no_ack", saw_ack, 1'b0);
        chk("drain_busy_held", early_idle, 1'b0);
        chk("drain_completed", sb.size(), 0);
        @(negedge CLK);
        chk("drain_idle_busy", busy, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge CLK); #1;

        // Reset two cycles after an issue: the operation must never respond.
        en = 1'b1;
        set_op(1'b0, 8'd90, 8'd9, 8'd10, 8'd0, 1'b0);
        issue1(1'b0, 0);
        @(posedge CLK); #1;
        RSTa = 1'b0;
        en = 1'b0;
        @(negedge CLK);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_rsp_valid", rsp_valid, 1'b0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RSTa = 1'b1;
        repeat (20) @(negedge CLK);
        chk("after_reset_busy", busy, 1'b0);
        chk("after_reset_no_pending", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
